// File: rtl/node_id_alloc.sv
// -----------------------------------------------------------------------------
// node_id_alloc
//
// Hands out fresh hidden-node IDs to the add-node mutation. A genome scan
// (driven by the max-ID scan stage) finds the largest hidden node ID in use.
// One settle cycle later that maximum is sampled, and the block offers IDs
// starting just above it, or at HIDDEN_BASE if the genome has no hidden nodes
// yet. IDs are issued one per accepted valid/ready transfer until ID_LIMIT has
// been issued. After that the block reports exhausted.
//
// Ports
//   clk              clock
//   rst              asynchronous, active-high reset
//   scan_start       1-cycle pulse: begin a genome scan (overrides everything)
//   scan_done        1-cycle pulse: the last gene has reached the scanner
//   hidden_node_max  registered running max hidden ID from the scan stage
//   alloc_ready      consumer accepts alloc_id this cycle
//   scan_state       to scan stage: 0 = scanning, 1 = hold
//   alloc_valid      alloc_id holds a valid new hidden node ID
//   alloc_id         offered node ID
//   alloc_count      IDs issued since the last scan_start (saturating)
//   exhausted        no further ID can be issued
//   busy             scan or settle in progress
// -----------------------------------------------------------------------------
module node_id_alloc #(
  parameter int                  ATTR_SZ     = 8,
  parameter logic [ATTR_SZ-1:0]  HIDDEN_BASE = 8'd16,
  parameter logic [ATTR_SZ-1:0]  ID_LIMIT    = 8'd255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scan_start,
  input  logic               scan_done,
  input  logic [ATTR_SZ-1:0] hidden_node_max,
  input  logic               alloc_ready,
  output logic               scan_state,
  output logic               alloc_valid,
  output logic [ATTR_SZ-1:0] alloc_id,
  output logic [ATTR_SZ-1:0] alloc_count,
  output logic               exhausted,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SETTLE,
    READY,
    EXHAUSTED
  } state_t;

  state_t state;

  // First candidate ID after a scan. It is one bit wider than an ID so that
  // max+1 carrying out of ATTR_SZ bits is seen as "beyond the limit" rather
  // than wrapping to a small ID that is already in use.
  logic [ATTR_SZ:0] cand;
  logic             cand_over;

  always_comb begin
    if (hidden_node_max < HIDDEN_BASE) begin
      cand = {1'b0, HIDDEN_BASE};
    end else begin
      cand = {1'b0, hidden_node_max} + {{ATTR_SZ{1'b0}}, 1'b1};
    end
    cand_over = (cand > {1'b0, ID_LIMIT});
  end

  // alloc_id doubles as next_id. While READY, the offered ID is exactly the
  // next one to be issued, so a second register would only duplicate it.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset is in the sensitivity list, which
  // makes it take effect immediately rather than at the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scan_state  <= 1'b1;
      alloc_valid <= 1'b0;
      alloc_id    <= '0;
      alloc_count <= '0;
      exhausted   <= 1'b0;
      busy        <= 1'b0;
    end else if (scan_start) begin
      // A new scan restarts from any state, even mid-handshake.
      state       <= SCAN;
      scan_state  <= 1'b0;
      alloc_valid <= 1'b0;
      alloc_count <= '0;
      exhausted   <= 1'b0;
      busy        <= 1'b1;
    end else begin
      case (state)
        SCAN: begin
          if (scan_done) begin
            state      <= SETTLE;
            scan_state <= 1'b1;
          end
        end

        // The final gene's update of hidden_node_max lands during this
        // cycle, so it is sampled on the way out.
        SETTLE: begin
          busy <= 1'b0;
          if (cand_over) begin
            state     <= EXHAUSTED;
            exhausted <= 1'b1;
          end else begin
            state       <= READY;
            alloc_valid <= 1'b1;
            alloc_id    <= cand[ATTR_SZ-1:0];
          end
        end

        READY: begin
          if (alloc_ready) begin
            if (alloc_count != '1) begin
              alloc_count <= alloc_count + ATTR_SZ'(1);
            end
            if (alloc_id == ID_LIMIT) begin
              state       <= EXHAUSTED;
              alloc_valid <= 1'b0;
              exhausted   <= 1'b1;
            end else begin
              alloc_id <= alloc_id + ATTR_SZ'(1);
            end
          end
        end

        // IDLE and EXHAUSTED wait for scan_start; scan_done and alloc_ready
        // are ignored there.
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_node_id_alloc.sv
// -----------------------------------------------------------------------------
// tb_node_id_alloc
//
// Self-checking bench for node_id_alloc with the default parameters
// (8-bit IDs, base 16, limit 255). The reference model is transactional.
// A scan ending at maximum m gives the first ID first = (m < 16) ? 16 : m + 1.
// After t transfers, the offered ID is first + t. The block stays valid while
// that value is <= 255 and is exhausted otherwise. The count is min(t, 255).
// Directed scenarios cover the listed cases, then randomized scans and
// ready patterns follow.
// -----------------------------------------------------------------------------
module tb_node_id_alloc;

  localparam int BASE  = 16;
  localparam int LIMIT = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_start;
  logic       scan_done;
  logic [7:0] hidden_node_max;
  logic       alloc_ready;
  logic       scan_state;
  logic       alloc_valid;
  logic [7:0] alloc_id;
  logic [7:0] alloc_count;
  logic       exhausted;
  logic       busy;

  node_id_alloc dut (
    .clk             (clk),
    .rst             (rst),
    .scan_start      (scan_start),
    .scan_done       (scan_done),
    .hidden_node_max (hidden_node_max),
    .alloc_ready     (alloc_ready),
    .scan_state      (scan_state),
    .alloc_valid     (alloc_valid),
    .alloc_id        (alloc_id),
    .alloc_count     (alloc_count),
    .exhausted       (exhausted),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: first ID after the last scan, transfers since.
  int exp_first;
  int xfers;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".scan_state"},  32'(scan_state),  1);
    check({tag, ".alloc_valid"}, 32'(alloc_valid), 0);
    check({tag, ".alloc_id"},    32'(alloc_id),    0);
    check({tag, ".alloc_count"}, 32'(alloc_count), 0);
    check({tag, ".exhausted"},   32'(exhausted),   0);
    check({tag, ".busy"},        32'(busy),        0);
  endtask

  // Compare post-scan outputs with the arithmetic model.
  task automatic check_offer(input string tag);
    int nid;
    nid = exp_first + xfers;
    check({tag, ".scan_state"},  32'(scan_state),  1);
    check({tag, ".busy"},        32'(busy),        0);
    check({tag, ".alloc_count"}, 32'(alloc_count), (xfers > 255) ? 255 : xfers);
    if (nid <= LIMIT) begin
      check({tag, ".alloc_valid"}, 32'(alloc_valid), 1);
      check({tag, ".exhausted"},   32'(exhausted),   0);
      check({tag, ".alloc_id"},    32'(alloc_id),    nid);
    end else begin
      check({tag, ".alloc_valid"}, 32'(alloc_valid), 0);
      check({tag, ".exhausted"},   32'(exhausted),   1);
      // The last ID issued stays on alloc_id once the limit is consumed.
      if (xfers > 0) check({tag, ".alloc_id_last"}, 32'(alloc_id), LIMIT);
    end
  endtask

  task automatic start_scan(input string tag);
    scan_start  = 1'b1;
    alloc_ready = 1'($urandom_range(0, 1));
    step();
    scan_start  = 1'b0;
    xfers       = 0;
    check({tag, ".scan_state"},  32'(scan_state),  0);
    check({tag, ".busy"},        32'(busy),        1);
    check({tag, ".alloc_valid"}, 32'(alloc_valid), 0);
    check({tag, ".alloc_count"}, 32'(alloc_count), 0);
    check({tag, ".exhausted"},   32'(exhausted),   0);
  endtask

  // Scan for len cycles with noise on the max input, then end on m.
  task automatic finish_scan(input string tag, input int m, input int len);
    for (int i = 0; i < len; i++) begin
      hidden_node_max = 8'($urandom_range(0, 255));
      alloc_ready     = 1'($urandom_range(0, 1));
      step();
      check({tag, ".scanning"}, 32'(scan_state), 0);
    end
    hidden_node_max = 8'(m);
    scan_done       = 1'b1;
    step();
    scan_done = 1'b0;
    // SETTLE: scanner held, still busy, nothing offered.
    check({tag, ".settle_state"}, 32'(scan_state),  1);
    check({tag, ".settle_busy"},  32'(busy),        1);
    check({tag, ".settle_valid"}, 32'(alloc_valid), 0);
    step();
    exp_first = (m < BASE) ? BASE : m + 1;
    check_offer({tag, ".offer"});
  endtask

  // mode 0: random ready, 1: ready held high, 2: ready held low.
  task automatic ready_cycles(input string tag, input int n, input int mode);
    logic r;
    for (int i = 0; i < n; i++) begin
      r = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 1);
      alloc_ready = r;
      step();
      if (r && (exp_first + xfers <= LIMIT)) xfers++;
      check_offer(tag);
    end
    alloc_ready = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    scan_start      = 1'b0;
    scan_done       = 1'b0;
    hidden_node_max = '0;
    alloc_ready     = 1'b0;
    #12;
    check_reset_values("reset");
    rst = 1'b0;
    // Stays idle with no scan_start, even with ready and done wiggling.
    alloc_ready = 1'b1;
    scan_done   = 1'b1;
    step();
    step();
    scan_done   = 1'b0;
    alloc_ready = 1'b0;
    check_reset_values("idle_hold");

    // Max 40 -> offer 41, count 0; ready low 5 cycles holds the offer.
    start_scan("s40");
    finish_scan("s40", 40, 3);
    ready_cycles("hold41", 5, 2);
    // scan_start together with ready: restart wins, no transfer.
    scan_start  = 1'b1;
    alloc_ready = 1'b1;
    step();
    scan_start  = 1'b0;
    alloc_ready = 1'b0;
    xfers       = 0;
    check("restart.alloc_count", 32'(alloc_count), 0);
    check("restart.alloc_valid", 32'(alloc_valid), 0);
    check("restart.scan_state",  32'(scan_state),  0);
    check("restart.busy",        32'(busy),        1);

    // Below base -> 16, then 16,17,18 back to back.
    finish_scan("s3", 3, 2);
    ready_cycles("b2b", 3, 1);
    check("b2b.count3", 32'(alloc_count), 3);

    // 254 -> offer 255, one transfer exhausts, extra ready ignored.
    start_scan("s254");
    finish_scan("s254", 254, 1);
    ready_cycles("last", 1, 1);
    check("last.exhausted", 32'(exhausted), 1);
    ready_cycles("exh_ready", 3, 1);

    // 255 -> exhausted straight out of SETTLE.
    start_scan("s255");
    finish_scan("s255", 255, 0);
    ready_cycles("exh_direct", 2, 1);

    // Asynchronous reset mid-scan: outputs drop without a clock edge.
    start_scan("rs_scan");
    hidden_node_max = 8'd50;
    step();
    #2 rst = 1'b1;
    #1 check_reset_values("rst_mid_scan");
    #2 rst = 1'b0;
    step();
    scan_done = 1'b1;
    step();
    scan_done = 1'b0;
    step();
    check_reset_values("done_after_rst");

    // Asynchronous reset mid-handshake.
    start_scan("rs_rdy");
    finish_scan("rs_rdy", 100, 1);
    alloc_ready = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_values("rst_mid_ready");
    alloc_ready = 1'b0;
    #2 rst = 1'b0;
    step();
    check_reset_values("after_rst_ready");

    // Randomized scans, biased so that exhaustion happens regularly.
    for (int k = 0; k < 24; k++) begin
      int m;
      m = ($urandom_range(0, 1) == 1) ? $urandom_range(230, 255)
                                       : $urandom_range(0, 255);
      start_scan("rnd");
      finish_scan("rnd", m, $urandom_range(0, 4));
      ready_cycles("rnd", $urandom_range(5, 40), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/node_id_alloc.md
NODE_ID_ALLOC -- requirements
Module: node_id_alloc

Interface
REQ-001 Parameter ATTR_SZ, default 8, SHALL set the node-ID width.
REQ-002 Parameter HIDDEN_BASE, default 8'd16, SHALL be the first ID usable for hidden nodes.
REQ-003 Parameter ID_LIMIT, default 8'd255, SHALL be the largest ID that may be issued.
REQ-004 clk  in  1  SHALL be the clock.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 scan_start  in  1  SHALL be a one-cycle pulse that begins a genome scan.
REQ-007 scan_done  in  1  SHALL be a one-cycle pulse marking that the last gene has been presented to the max-ID scanner.
REQ-008 hidden_node_max  in  ATTR_SZ  SHALL be the registered running maximum hidden node ID from the scan stage.
REQ-009 alloc_ready  in  1  SHALL be asserted by the consumer (add-node mutation) to accept alloc_id.
REQ-010 scan_state  out  1  SHALL drive the scan stage state input: 0 = scanning, 1 = hold.
REQ-011 alloc_valid  out  1  SHALL indicate that alloc_id is a valid new hidden node ID.
REQ-012 alloc_id  out  ATTR_SZ  SHALL carry the offered node ID.
REQ-013 alloc_count  out  ATTR_SZ  SHALL give the number of IDs issued since the last scan_start.
REQ-014 exhausted  out  1  SHALL indicate that no further ID can be issued.
REQ-015 busy  out  1  SHALL be high in SCAN and SETTLE.

Function
REQ-016 The FSM SHALL have the states IDLE, SCAN, SETTLE, READY and EXHAUSTED, registered on posedge clk.
REQ-017 scan_start in any state SHALL move to SCAN next cycle, clear alloc_count to 0 and deassert alloc_valid; it SHALL take priority over every other input in the same cycle.
REQ-018 scan_state SHALL be 0 only in SCAN and 1 in all other states.
REQ-019 scan_done in SCAN SHALL move to SETTLE; scan_done outside SCAN SHALL be ignored.
REQ-020 SETTLE SHALL last exactly one cycle, so the final gene's update of hidden_node_max is visible before it is sampled.
REQ-021 On leaving SETTLE, the block SHALL compute cand = (hidden_node_max < HIDDEN_BASE) ? HIDDEN_BASE : hidden_node_max + 1, evaluated ATTR_SZ+1 bits wide.
REQ-022 If cand > ID_LIMIT (including a carry out), the next state SHALL be EXHAUSTED; otherwise next_id SHALL be set to cand and the next state SHALL be READY.
REQ-023 In READY, alloc_valid SHALL be 1 and alloc_id SHALL equal next_id.
REQ-024 alloc_valid and alloc_id SHALL hold stable until a transfer; alloc_valid SHALL NOT drop without a transfer except on scan_start or rst.
REQ-025 A transfer SHALL occur on a cycle with alloc_valid & alloc_ready; on that edge alloc_count SHALL increment by 1.
REQ-026 After a transfer, if alloc_id == ID_LIMIT the next state SHALL be EXHAUSTED; otherwise next_id SHALL increment by 1 and READY SHALL be held, allowing back-to-back transfers of one ID per cycle.
REQ-027 In EXHAUSTED, exhausted SHALL be 1, alloc_valid SHALL be 0, and alloc_ready SHALL be ignored.
REQ-028 alloc_count SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 In IDLE, SCAN and SETTLE, alloc_valid SHALL be 0 and alloc_ready SHALL be ignored.
REQ-030 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 rst SHALL immediately force state IDLE, scan_state=1, alloc_valid=0, alloc_id=0, alloc_count=0, exhausted=0 and busy=0, including mid-scan or mid-handshake.
REQ-032 After rst deasserts, the block SHALL remain in IDLE until scan_start.

Verification
REQ-033 scan_start; stage max reaches 8'd40; scan_done -> scan_state 0 during scan; SETTLE 1 cycle; READY with alloc_id=41, alloc_count=0.
REQ-034 Scan with hidden_node_max=3 (below base) -> alloc_id=16; three transfers with alloc_ready held high -> IDs 16,17,18 on consecutive cycles; alloc_count=3.
REQ-035 hidden_node_max=254; one transfer (ID 255) -> EXHAUSTED, exhausted=1, alloc_valid=0; alloc_ready high afterwards -> no change.
REQ-036 hidden_node_max=255 at SETTLE exit -> EXHAUSTED directly, with no alloc_valid pulse.
REQ-037 alloc_ready low for 5 cycles in READY -> alloc_id held at 41 and alloc_valid held at 1; scan_start together with alloc_ready -> no transfer, alloc_count=0, state SCAN.
REQ-038 rst asserted mid-SCAN and again mid-READY -> all outputs take reset values asynchronously; scan_done after reset release -> ignored.
